// File: rtl/div_unit_pkg.sv
// ============================================================================
// Module : div_unit_pkg
// Brief  : Shared RV32M divide opcodes and divider state encodings.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package div_unit_pkg;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module : div_unit
// Brief  : Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  div_state_e      r_state;
  logic [4:0]      r_cnt;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd_tag;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN:0]   r_dvsr;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd_out;

  logic            w_start_signed;
  logic            w_start_rem;
  logic            w_dvnd_neg;
  logic            w_dvsr_neg;
  logic [XLEN:0]   w_dvnd_ext;
  logic [XLEN:0]   w_dvsr_ext;
  logic [XLEN:0]   w_dvnd_abs;
  logic [XLEN:0]   w_dvsr_abs;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_is_rem;
  logic [XLEN:0]   w_shift_rem;
  logic [XLEN+1:0] w_trial;
  logic            w_borrow;
  logic [XLEN:0]   w_next_rem;
  logic            w_unused;

  assign w_start_signed = (funct3_i == F3_DIV) || (funct3_i == F3_REM);
  assign w_start_rem    = (funct3_i == F3_REM) || (funct3_i == F3_REMU);
  assign w_dvnd_neg     = w_start_signed & dividend_i[XLEN-1];
  assign w_dvsr_neg     = w_start_signed & divisor_i[XLEN-1];

  // 33-bit magnitudes so that |0x80000000| stays representable
  assign w_dvnd_ext = {w_dvnd_neg, dividend_i};
  assign w_dvsr_ext = {w_dvsr_neg, divisor_i};
  assign w_dvnd_abs = w_dvnd_neg ? -w_dvnd_ext : w_dvnd_ext;
  assign w_dvsr_abs = w_dvsr_neg ? -w_dvsr_ext : w_dvsr_ext;

  assign w_div_zero = (divisor_i == '0);
  assign w_ovf      = w_start_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                      && (divisor_i == '1);
  assign w_is_rem   = (r_funct3 == F3_REM) || (r_funct3 == F3_REMU);

  // One restoring step: shift rem:quo left, trial-subtract, keep on no borrow
  assign w_shift_rem = {r_rem, r_quo[XLEN-1]};
  assign w_trial     = {1'b0, w_shift_rem} - {1'b0, r_dvsr};
  assign w_borrow    = w_trial[XLEN+1];
  assign w_next_rem  = w_borrow ? w_shift_rem : w_trial[XLEN:0];

  assign w_unused = &{1'b0, w_next_rem[XLEN], w_dvnd_abs[XLEN]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_rd_tag <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i && !flush_i) begin
            r_funct3 <= funct3_i;
            r_rd_tag <= rd_addr_i;
            r_neg_q  <= w_dvnd_neg ^ w_dvsr_neg;
            r_neg_r  <= w_dvnd_neg;
            r_rem    <= '0;
            r_quo    <= w_dvnd_abs[XLEN-1:0];
            r_dvsr   <= w_dvsr_abs;
            r_cnt    <= 5'd31;
            // Divide-by-zero takes precedence over signed overflow
            if (w_div_zero) begin
              r_result <= w_start_rem ? dividend_i : '1;
              r_rd_out <= rd_addr_i;
              r_state  <= ST_DONE;
            end else if (w_ovf) begin
              r_result <= w_start_rem ? '0 : dividend_i;
              r_rd_out <= rd_addr_i;
              r_state  <= ST_DONE;
            end else begin
              r_state  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush_i) begin
            r_state <= ST_IDLE;
          end else begin
            r_rem <= w_next_rem[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], ~w_borrow};
            if (r_cnt == 5'd0) begin
              r_state <= ST_FIX;
            end else begin
              r_cnt <= r_cnt - 5'd1;
            end
          end
        end
        ST_FIX: begin
          if (flush_i) begin
            r_state <= ST_IDLE;
          end else begin
            if (w_is_rem) begin
              r_result <= r_neg_r ? -r_rem : r_rem;
            end else begin
              r_result <= r_neg_q ? -r_quo : r_quo;
            end
            r_rd_out <= r_rd_tag;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o    = (r_state != ST_IDLE);
  assign done_o    = (r_state == ST_DONE);
  assign result_o  = r_result;
  assign rd_addr_o = r_rd_out;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module : tb_div_unit
// Brief  : Directed self-checking bench for div_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  div_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .funct3_i   (funct3_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o)
  );

  always #5 clk = ~clk;

  // Issue one op and wait for done_o; lat counts edges from the start edge (0 = timeout)
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res,
                        output logic [4:0] rdo, output int lat);
    funct3_i = f3; dividend_i = a; divisor_i = b; rd_addr_i = rd; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done_o) lat = 0;
    res = result_o;
    rdo = rd_addr_o;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b1; flush_i = 1'b1;
    funct3_i = OP_DIVU; dividend_i = 32'd10; divisor_i = 32'd2; rd_addr_i = 5'd4;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: busy=%b done=%b expected 0 0", busy_o, done_o);
    end
    n_checks++;
    if (result_o !== 32'h0 || rd_addr_o !== 5'd0) begin
      n_fail++; $display("FAIL reset_data: result=%h rd=%0d expected 0 0", result_o, rd_addr_o);
    end
    rst = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    logic [31:0] res; logic [4:0] rdo; int lat;
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd1, res, rdo, lat);
    n_checks++;
    if (res !== 32'd14 || rdo !== 5'd1) begin
      n_fail++; $display("FAIL divu_100_7: result=%h rd=%0d expected 0000000e 1", res, rdo);
    end
    n_checks++;
    if (lat !== 34) begin
      n_fail++; $display("FAIL divu_latency: got %0d expected 34", lat);
    end
    n_checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL done_one_cycle: done=%b busy=%b expected 0 0", done_o, busy_o);
    end
    run_op(OP_REMU, 32'd100, 32'd7, 5'd2, res, rdo, lat);
    n_checks++;
    if (res !== 32'd2 || lat !== 34) begin
      n_fail++; $display("FAIL remu_100_7: result=%h lat=%0d expected 00000002 34", res, lat);
    end
  endtask

  task automatic test_signed();
    logic [31:0] res; logic [4:0] rdo; int lat;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd3, res, rdo, lat);
    n_checks++;
    if (res !== 32'hFFFFFFFD || lat !== 34) begin
      n_fail++; $display("FAIL div_m7_2: result=%h lat=%0d expected fffffffd 34", res, lat);
    end
    run_op(OP_REM, 32'hFFFFFFF9, 32'd2, 5'd3, res, rdo, lat);
    n_checks++;
    if (res !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL rem_m7_2: result=%h expected ffffffff", res);
    end
    run_op(OP_REM, 32'd7, 32'hFFFFFFFE, 5'd3, res, rdo, lat);
    n_checks++;
    if (res !== 32'd1) begin
      n_fail++; $display("FAIL rem_7_m2: result=%h expected 00000001", res);
    end
    run_op(OP_DIV, 32'h80000000, 32'd1, 5'd3, res, rdo, lat);
    n_checks++;
    if (res !== 32'h80000000 || lat !== 34) begin
      n_fail++; $display("FAIL div_min_1: result=%h lat=%0d expected 80000000 34", res, lat);
    end
  endtask

  task automatic test_special();
    logic [31:0] res; logic [4:0] rdo; int lat;
    run_op(OP_DIVU, 32'd5, 32'd0, 5'd10, res, rdo, lat);
    n_checks++;
    if (res !== 32'hFFFFFFFF || lat !== 1 || rdo !== 5'd10) begin
      n_fail++; $display("FAIL divu_by_zero: result=%h lat=%0d rd=%0d expected ffffffff 1 10", res, lat, rdo);
    end
    run_op(OP_REM, 32'd5, 32'd0, 5'd11, res, rdo, lat);
    n_checks++;
    if (res !== 32'd5 || lat !== 1) begin
      n_fail++; $display("FAIL rem_by_zero: result=%h lat=%0d expected 00000005 1", res, lat);
    end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd12, res, rdo, lat);
    n_checks++;
    if (res !== 32'h80000000 || lat !== 1) begin
      n_fail++; $display("FAIL div_overflow: result=%h lat=%0d expected 80000000 1", res, lat);
    end
    run_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd13, res, rdo, lat);
    n_checks++;
    if (res !== 32'h0 || lat !== 1) begin
      n_fail++; $display("FAIL rem_overflow: result=%h lat=%0d expected 00000000 1", res, lat);
    end
  endtask

  task automatic test_busy_ignore();
    int ndone = 0; int first = 0;
    logic [31:0] res = '0; logic [4:0] rdo = '0;
    funct3_i = OP_DIVU; dividend_i = 32'd9; divisor_i = 32'd3; rd_addr_i = 5'd5; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    funct3_i = OP_DIVU; dividend_i = 32'd50; divisor_i = 32'd5; rd_addr_i = 5'd7; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 4; c <= 45; c++) begin
      @(posedge clk); #1;
      if (done_o) begin
        ndone++;
        if (first == 0) begin first = c; res = result_o; rdo = rd_addr_o; end
      end
    end
    n_checks++;
    if (ndone !== 1 || first !== 34) begin
      n_fail++; $display("FAIL busy_ignore_done: pulses=%0d at=%0d expected 1 34", ndone, first);
    end
    n_checks++;
    if (res !== 32'd3 || rdo !== 5'd5) begin
      n_fail++; $display("FAIL busy_ignore_data: result=%h rd=%0d expected 00000003 5", res, rdo);
    end
  endtask

  task automatic test_flush();
    logic [31:0] res; logic [4:0] rdo; int lat; int ndone = 0;
    funct3_i = OP_DIVU; dividend_i = 32'd100; divisor_i = 32'd7; rd_addr_i = 5'd20; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_calc: busy=%b done=%b expected 0 0", busy_o, done_o);
    end
    n_checks++;
    if (result_o !== 32'd3 || rd_addr_o !== 5'd5) begin
      n_fail++; $display("FAIL flush_hold: result=%h rd=%0d expected 00000003 5", result_o, rd_addr_o);
    end
    // Start coincident with flush in IDLE must be dropped
    funct3_i = OP_DIVU; dividend_i = 32'd8; divisor_i = 32'd2; rd_addr_i = 5'd21;
    start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done_o || busy_o) ndone++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (ndone !== 0) begin
      n_fail++; $display("FAIL flush_idle_drop: active cycles=%0d expected 0", ndone);
    end
    run_op(OP_DIV, 32'd20, 32'hFFFFFFFC, 5'd9, res, rdo, lat);
    n_checks++;
    if (res !== 32'hFFFFFFFB || lat !== 34 || rdo !== 5'd9) begin
      n_fail++; $display("FAIL div_20_m4: result=%h lat=%0d rd=%0d expected fffffffb 34 9", res, lat, rdo);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic [4:0] rdo; int lat; int ndone = 0;
    funct3_i = OP_REMU; dividend_i = 32'd100; divisor_i = 32'd7; rd_addr_i = 5'd15; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0 || rd_addr_o !== 5'd0) begin
      n_fail++; $display("FAIL reset_mid: busy=%b done=%b result=%h rd=%0d expected 0 0 0 0",
                         busy_o, done_o, result_o, rd_addr_o);
    end
    for (int c = 0; c < 25; c++) begin
      if (done_o) ndone++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (ndone !== 0) begin
      n_fail++; $display("FAIL reset_mid_nodone: pulses=%0d expected 0", ndone);
    end
    run_op(OP_REMU, 32'd17, 32'd5, 5'd6, res, rdo, lat);
    n_checks++;
    if (res !== 32'd2 || lat !== 34 || rdo !== 5'd6) begin
      n_fail++; $display("FAIL remu_17_5: result=%h lat=%0d rd=%0d expected 00000002 34 6", res, lat, rdo);
    end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = '0; dividend_i = '0; divisor_i = '0; rd_addr_i = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_busy_ignore();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
